// File: rtl/display_scheduler.sv
// Display mux sequencer: auto rotation with dwell and skip mask, manual override, alarm pre-emption.
// Every select change passes through one SETTLE cycle so out_valid only rises once the mux register has caught up.
module display_scheduler #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               manual,
   input  logic [2:0]         manual_sel,
   input  logic [4:0]         skip_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               alarm_req,
   input  logic [2:0]         alarm_ch,
   output logic [2:0]         sel,
   output logic               out_valid,
   output logic               ch_start,
   output logic               frame_done
);

   typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;

   state_t             state, state_next;
   logic [2:0]         resume, resume_next, sel_next;
   logic [2:0]         target, auto_ch, adv_ch;
   logic [DWELL_W-1:0] cnt, cnt_next, last_cnt;
   logic               out_valid_next, ch_start_next, frame_done_next;
   logic               auto_mode;

   function automatic logic [2:0] clamp(input logic [2:0] ch);
      return (ch > 3'd4) ? 3'd0 : ch;
   endfunction

   function automatic logic [2:0] wrap5(input logic [2:0] start, input logic [2:0] off);
      logic [3:0] s;
      s = {1'b0, start} + {1'b0, off};
      return (s > 4'd4) ? 3'(s - 4'd5) : s[2:0];
   endfunction

   // First unmasked channel at offset >= first_off from start, modulo 5; start itself if none qualifies
   function automatic logic [2:0] scan(input logic [2:0] start, input logic [4:0] mask,
                                       input int first_off);
      logic [2:0] c;
      scan = start;
      for (int off = 4; off >= 0; off--) begin
         c = wrap5(start, 3'(off));
         if (off >= first_off && !mask[c])
            scan = c;
      end
   endfunction

   assign auto_mode = !alarm_req && !manual;
   assign auto_ch   = scan(resume, skip_mask, 0);
   assign adv_ch    = scan(sel, skip_mask, 1);
   assign target    = alarm_req ? clamp(alarm_ch) : (manual ? clamp(manual_sel) : auto_ch);
   assign last_cnt  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= 3'd0;
         resume     <= 3'd0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         ch_start   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         sel        <= sel_next;
         resume     <= resume_next;
         cnt        <= cnt_next;
         out_valid  <= out_valid_next;
         ch_start   <= ch_start_next;
         frame_done <= frame_done_next;
      end
   end

   // A lone unmasked channel (or a fully masked set) makes the advance land on sel itself; that is treated as a frozen reload.
   always_comb begin
      state_next      = state;
      sel_next        = sel;
      resume_next     = resume;
      cnt_next        = cnt;
      out_valid_next  = 1'b0;
      ch_start_next   = 1'b0;
      frame_done_next = 1'b0;
      if (!enable) begin
         state_next = IDLE;
         if (state != IDLE)
            resume_next = sel;
      end else begin
         case (state)
            IDLE: begin
               state_next    = SETTLE;
               sel_next      = target;
               ch_start_next = 1'b1;
               cnt_next      = '0;
            end
            SETTLE: begin
               if (target != sel) begin
                  sel_next      = target;
                  ch_start_next = 1'b1;
               end else begin
                  state_next     = DWELL;
                  out_valid_next = 1'b1;
               end
               cnt_next = '0;
            end
            DWELL: begin
               if (target != sel) begin
                  state_next    = SETTLE;
                  sel_next      = target;
                  ch_start_next = 1'b1;
                  cnt_next      = '0;
               end else if (!auto_mode) begin
                  out_valid_next = 1'b1;
                  cnt_next       = '0;
               end else if (cnt >= last_cnt) begin
                  cnt_next = '0;
                  if (adv_ch != sel) begin
                     state_next      = SETTLE;
                     sel_next        = adv_ch;
                     ch_start_next   = 1'b1;
                     frame_done_next = (adv_ch < sel);
                  end else begin
                     out_valid_next = 1'b1;
                  end
               end else begin
                  out_valid_next = 1'b1;
                  cnt_next       = cnt + DWELL_W'(1);
               end
            end
            default: state_next = IDLE;
         endcase
         if (auto_mode)
            resume_next = sel_next;
      end
   end

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed literal scenarios, then randomized traffic,
// all checked every cycle against a countdown-based channel model.
module tb_display_scheduler;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        manual;
   logic [2:0]  manual_sel;
   logic [4:0]  skip_mask;
   logic [15:0] dwell;
   logic        alarm_req;
   logic [2:0]  alarm_ch;
   logic [2:0]  sel;
   logic        out_valid;
   logic        ch_start;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 0;

   int sel_log[$];
   int exp_log[$];
   int fd_cnt;
   int ov_cnt;
   bit found;

   int m_phase;
   int m_sel;
   int m_resume;
   int m_left;
   int m_ov;
   int m_cs;
   int m_fd;
   int dlen;
   int tgt;
   int nxt;
   bit is_auto;

   display_scheduler #(.DWELL_W(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .manual(manual),
      .manual_sel(manual_sel),
      .skip_mask(skip_mask),
      .dwell(dwell),
      .alarm_req(alarm_req),
      .alarm_ch(alarm_ch),
      .sel(sel),
      .out_valid(out_valid),
      .ch_start(ch_start),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   function automatic int clampi(input int ch);
      return (ch > 4) ? 0 : ch;
   endfunction

   function automatic int first_open(input int start, input int first_off, input logic [4:0] mask);
      for (int k = first_off; k < 5; k++)
         if (!mask[(start + k) % 5])
            return (start + k) % 5;
      return start;
   endfunction

   // Model: phase 0 off, 1 settling, 2 showing; m_left counts showing cycles still owed to the channel.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase  = 0;
         m_sel    = 0;
         m_resume = 0;
         m_left   = 0;
         m_ov     = 0;
         m_cs     = 0;
         m_fd     = 0;
      end else begin
         dlen    = (dwell == 16'd0) ? 1 : int'(dwell);
         is_auto = !alarm_req && !manual;
         tgt     = alarm_req ? clampi(int'(alarm_ch)) :
                   manual    ? clampi(int'(manual_sel)) : first_open(m_resume, 0, skip_mask);
         m_cs = 0;
         m_fd = 0;
         if (!enable) begin
            if (m_phase != 0)
               m_resume = m_sel;
            m_phase = 0;
            m_ov    = 0;
         end else if (m_phase == 0 || tgt != m_sel) begin
            m_phase = 1;
            m_sel   = tgt;
            m_cs    = 1;
            m_ov    = 0;
         end else if (m_phase == 1) begin
            m_phase = 2;
            m_ov    = 1;
            m_left  = dlen;
         end else if (!is_auto) begin
            m_left = dlen;
         end else if (m_left > 1) begin
            m_left--;
         end else begin
            nxt = first_open(m_sel, 1, skip_mask);
            if (nxt != m_sel) begin
               m_fd    = (nxt < m_sel) ? 1 : 0;
               m_sel   = nxt;
               m_phase = 1;
               m_cs    = 1;
               m_ov    = 0;
            end else begin
               m_left = dlen;
            end
         end
         if (enable && is_auto)
            m_resume = m_sel;
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (rst_n && cmp_on) begin
         check("sel", int'(sel), m_sel);
         check("out_valid", int'(out_valid), m_ov);
         check("ch_start", int'(ch_start), m_cs);
         check("frame_done", int'(frame_done), m_fd);
      end
   end

   task automatic watch(input int n);
      sel_log.delete();
      fd_cnt = 0;
      ov_cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (ch_start)
            sel_log.push_back(int'(sel));
         fd_cnt += int'(frame_done);
         ov_cnt += int'(out_valid);
      end
   endtask

   task automatic check_log(input string name);
      check({name, "_len"}, sel_log.size(), exp_log.size());
      for (int i = 0; i < sel_log.size() && i < exp_log.size(); i++)
         check($sformatf("%s_%0d", name, i), sel_log[i], exp_log[i]);
   endtask

   task automatic wait_sel(input int ch);
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (int'(sel) == ch && out_valid)
            found = 1;
      end
      check("wait_sel", int'(found), 1);
   endtask

   task automatic do_reset();
      #1;
      rst_n      = 1'b0;
      enable     = 1'b0;
      manual     = 1'b0;
      manual_sel = 3'd0;
      alarm_req  = 1'b0;
      alarm_ch   = 3'd0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic start_auto(input logic [4:0] mask, input logic [15:0] d);
      @(posedge clk);
      #1;
      skip_mask = mask;
      dwell     = d;
      manual    = 1'b0;
      enable    = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      manual     = 1'b0;
      manual_sel = 3'd0;
      skip_mask  = 5'd0;
      dwell      = 16'd3;
      alarm_req  = 1'b0;
      alarm_ch   = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sel", int'(sel), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_ch_start", int'(ch_start), 0);
      check("rst_frame_done", int'(frame_done), 0);
      rst_n  = 1'b1;
      cmp_on = 1;

      // Full rotation, dwell 3
      start_auto(5'b00000, 16'd3);
      watch(22);
      exp_log = '{0, 1, 2, 3, 4, 0};
      check_log("rotation");
      check("rotation_frame_done", fd_cnt, 1);
      check("rotation_valid_cycles", ov_cnt, 15);

      repeat (6) @(negedge clk);
      check("pre_reset_sel", int'(sel), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_sel", int'(sel), 0);
      check("async_rst_out_valid", int'(out_valid), 0);
      enable = 1'b0;
      #1;
      rst_n = 1'b1;

      // Masked rotation, then everything masked
      start_auto(5'b01010, 16'd2);
      watch(11);
      exp_log = '{0, 2, 4, 0};
      check_log("mask");
      check("mask_frame_done", fd_cnt, 1);
      @(posedge clk);
      #1;
      skip_mask = 5'b11111;
      watch(15);
      check("all_masked_starts", sel_log.size(), 0);
      check("all_masked_valid", ov_cnt, 15);
      check("all_masked_sel", int'(sel), 0);

      // Manual with clamp, then a manual change
      @(posedge clk);
      do_reset();
      @(posedge clk);
      #1;
      skip_mask  = 5'b00000;
      dwell      = 16'd2;
      manual     = 1'b1;
      manual_sel = 3'd6;
      enable     = 1'b1;
      watch(4);
      exp_log = '{0};
      check_log("manual_clamp");
      @(posedge clk);
      #1;
      manual_sel = 3'd3;
      watch(10);
      exp_log = '{3};
      check_log("manual_change");
      check("manual_valid_cycles", ov_cnt, 9);
      check("manual_sel_held", int'(sel), 3);

      // Dwell 0 behaves as dwell 1
      @(posedge clk);
      do_reset();
      start_auto(5'b00000, 16'd0);
      watch(11);
      exp_log = '{0, 1, 2, 3, 4};
      check_log("dwell0");
      check("dwell0_valid_cycles", ov_cnt, 5);

      // Alarm pre-emption and resume
      @(posedge clk);
      do_reset();
      start_auto(5'b00000, 16'd3);
      wait_sel(2);
      @(posedge clk);
      #1;
      alarm_req = 1'b1;
      alarm_ch  = 3'd3;
      @(posedge clk);
      @(negedge clk);
      check("alarm_sel", int'(sel), 3);
      check("alarm_ch_start", int'(ch_start), 1);
      watch(6);
      check("alarm_hold_starts", sel_log.size(), 0);
      check("alarm_hold_sel", int'(sel), 3);
      @(posedge clk);
      #1;
      alarm_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("release_sel", int'(sel), 2);
      check("release_ch_start", int'(ch_start), 1);
      watch(4);
      exp_log = '{3};
      check_log("release_next");
      check("release_valid_cycles", ov_cnt, 3);

      // Disable and re-enable resumes on the same channel
      @(posedge clk);
      do_reset();
      start_auto(5'b00000, 16'd3);
      wait_sel(2);
      @(posedge clk);
      #1;
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("disable_out_valid", int'(out_valid), 0);
      check("disable_sel", int'(sel), 2);
      repeat (3) @(negedge clk);
      check("idle_sel_hold", int'(sel), 2);
      @(posedge clk);
      #1;
      enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reenable_sel", int'(sel), 2);
      check("reenable_ch_start", int'(ch_start), 1);

      // Randomized traffic; dwell only changes on a cycle where enable is being held low
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (!rst_n)
            rst_n = 1'b1;
         else if ($urandom_range(0, 499) == 0)
            rst_n = 1'b0;
         if ($urandom_range(0, 49) == 0) begin
            enable = 1'b0;
            dwell  = 16'($urandom_range(0, 5));
         end else if (!enable && $urandom_range(0, 3) == 0) begin
            enable = 1'b1;
         end
         if ($urandom_range(0, 29) == 0)
            manual = ~manual;
         if ($urandom_range(0, 19) == 0)
            manual_sel = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 29) == 0) begin
            alarm_req = ~alarm_req;
            alarm_ch  = 3'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 39) == 0)
            skip_mask = ($urandom_range(0, 3) == 0) ? 5'h1f : 5'($urandom_range(0, 31));
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
